// File: rtl/post_pkg.sv
// +----------------------------------------------------------------------------+
// | post_pkg: shared state encoding, protocol constants and default timing for  |
// | the POST REQ/ACK host and pod blocks.                                       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package post_pkg;

    localparam int CMD_PULSES       = 4;
    localparam int DATA_BITS        = 8;
    localparam int CNT_W            = 4;

    localparam int DEF_PULSE_CYCLES = 1;
    localparam int DEF_GAP_CYCLES   = 2;
    localparam int DEF_BREAK_CYCLES = 50;
    localparam int DEF_POLL_MAX     = 255;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_BREAK  = 4'd1,
        ST_CMD    = 4'd2,
        ST_POLL   = 4'd3,
        ST_DATA   = 4'd4,
        ST_DECIDE = 4'd5,
        ST_CHAIN  = 4'd6,
        ST_END    = 4'd7
    } post_state_t;

    // States in which the slot timer is producing REQ pulses.
    function automatic logic is_run(input post_state_t s);
        return (s == ST_CMD) || (s == ST_POLL) || (s == ST_DATA) || (s == ST_CHAIN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/post_req_pulse.sv
// +----------------------------------------------------------------------------+
// | post_req_pulse: REQ slot timer. Produces REQ, rise/sample strobes, a per-   |
// | state pulse counter and the break timer.                                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module post_req_pulse
    import post_pkg::*;
#(
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int BREAK_CYCLES = DEF_BREAK_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             run_next,
    input  logic             brk,
    input  logic             cnt_clr,
    output logic             req,
    output logic             rise,
    output logic             sample,
    output logic             brk_done,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam int SLOT = PULSE_CYCLES + GAP_CYCLES;
    localparam int PH_W = $clog2(SLOT);
    localparam int BK_W = $clog2(BREAK_CYCLES + 1);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SLOT - 1);
    localparam logic [PH_W-1:0] PH_PULSE = PH_W'(PULSE_CYCLES);
    localparam logic [BK_W-1:0] BK_LAST  = BK_W'(BREAK_CYCLES - 1);

    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_next;
    logic [BK_W-1:0] bk;

    // Phase 0 of every slot is the first REQ-high cycle; a new slot starts
    // whenever the FSM stays in (or enters) a pulsing state at a slot boundary.
    always_comb begin
        ph_next = '0;
        if (run_next && run && (ph != PH_LAST)) begin
            ph_next = ph + 1'b1;
        end
    end

    assign rise     = run_next && (ph_next == '0);
    assign sample   = run && (ph == PH_LAST);
    assign brk_done = brk && (bk == BK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            ph        <= '0;
            req       <= 1'b0;
            bk        <= '0;
            pulse_cnt <= '0;
        end else begin
            ph  <= ph_next;
            req <= run_next && (ph_next < PH_PULSE);
            bk  <= (brk && !brk_done) ? bk + 1'b1 : '0;
            if (cnt_clr) begin
                pulse_cnt <= '0;
            end else if (sample) begin
                pulse_cnt <= pulse_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/post_host_input.sv
// +----------------------------------------------------------------------------+
// | post_host_input: host-side POST INPUT initiator; issues break + command,    |
// | polls y, shifts in a byte MSB first. Chaining enabled by POST_HOST_CHAIN_EN.|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module post_host_input
    import post_pkg::*;
#(
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int BREAK_CYCLES = DEF_BREAK_CYCLES,
    parameter int POLL_MAX     = DEF_POLL_MAX
) (
    input  logic        refclk,
    input  logic        reset,
    input  logic        start,
    input  logic        chain,
    output logic        testreq,
    input  logic        testack,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        timeout,
    output logic        pod_out_ready,
    output logic [15:0] req_count
);

`ifdef POST_HOST_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    localparam int PC_W = $clog2(POLL_MAX + 1);
    localparam logic [PC_W-1:0]  POLL_LAST = PC_W'(POLL_MAX - 1);
    localparam bit               POLL_ONE  = (POLL_MAX <= 1);
    localparam logic [CNT_W-1:0] CMD_X     = CNT_W'(CMD_PULSES - 2);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_PULSES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

    post_state_t      state;
    post_state_t      state_next;
    logic             ack_s1;
    logic             ack_s2;
    logic [6:0]       sr;
    logic [PC_W-1:0]  poll_cnt;
    logic             run;
    logic             run_next;
    logic             brk;
    logic             rise;
    logic             sample;
    logic             brk_done;
    logic [CNT_W-1:0] pulse_cnt;
    logic             timeout_hit;
    logic             cmd_last;
    logic             data_last;
    logic             slot_free;

    assign cmd_last  = sample && (pulse_cnt == CMD_LAST);
    assign data_last = sample && (pulse_cnt == DATA_LAST);
    assign slot_free = !rx_valid || rx_ready;

    post_req_pulse #(
        .PULSE_CYCLES (PULSE_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES),
        .BREAK_CYCLES (BREAK_CYCLES)
    ) u_pulse (
        .clk       (refclk),
        .rst       (reset),
        .run       (run),
        .run_next  (run_next),
        .brk       (brk),
        .cnt_clr   (state_next != state),
        .req       (testreq),
        .rise      (rise),
        .sample    (sample),
        .brk_done  (brk_done),
        .pulse_cnt (pulse_cnt)
    );

    always_ff @(posedge refclk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_BREAK;
            ST_BREAK:  if (brk_done) state_next = ST_CMD;
            ST_CMD: begin
                if (cmd_last) begin
                    if (ack_s2)        state_next = ST_DATA;
                    else if (POLL_ONE) state_next = ST_END;
                    else               state_next = ST_POLL;
                end
            end
            ST_POLL: begin
                if (sample) begin
                    if (ack_s2)                      state_next = ST_DATA;
                    else if (poll_cnt == POLL_LAST)  state_next = ST_END;
                end
            end
            ST_DATA:   if (data_last) state_next = ST_DECIDE;
            // rx_valid already holds the fresh byte here, so only an accept
            // this cycle frees the output register for the next chained byte.
            ST_DECIDE: state_next = (CHAIN_EN && chain && slot_free) ? ST_CHAIN : ST_END;
            ST_CHAIN:  if (sample) state_next = ack_s2 ? ST_DATA : ST_POLL;
            ST_END:    if (brk_done) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        run         = is_run(state);
        run_next    = is_run(state_next);
        brk         = (state == ST_BREAK) || (state == ST_END);
        timeout_hit = ((state == ST_CMD) || (state == ST_POLL)) && (state_next == ST_END);
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            ack_s1        <= 1'b0;
            ack_s2        <= 1'b0;
            sr            <= '0;
            poll_cnt      <= '0;
            req_count     <= '0;
            pod_out_ready <= 1'b0;
            timeout       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
        end else begin
            ack_s1  <= testack;
            ack_s2  <= ack_s1;
            timeout <= timeout_hit;
            if (rise) begin
                req_count <= req_count + 16'd1;
            end
            if ((state == ST_CMD) && sample && (pulse_cnt == CMD_X)) begin
                pod_out_ready <= ack_s2;
            end
            if (state == ST_DATA && sample) begin
                sr <= {sr[5:0], ack_s2};
            end
            if (cmd_last && (state == ST_CMD)) begin
                poll_cnt <= PC_W'(1);
            end else if ((state == ST_POLL) && sample && !ack_s2) begin
                poll_cnt <= poll_cnt + 1'b1;
            end else if (state == ST_DECIDE) begin
                poll_cnt <= '0;
            end
            // A byte completing while the previous one is still held is dropped
            // rather than overwriting it.
            if ((state == ST_DATA) && data_last && slot_free) begin
                rx_data  <= {sr, ack_s2};
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_post_host_input.sv
// +----------------------------------------------------------------------------+
// | tb_post_host_input: scoreboard bench for post_host_input with a queue-fed  |
// | pod ACK model.                                                              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_post_host_input;

    localparam int BREAK_CYC = 50;

    logic        refclk   = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        chain    = 1'b0;
    logic        testack  = 1'b0;
    logic        rx_ready = 1'b0;
    logic        testreq;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic        timeout;
    logic        pod_out_ready;
    logic [15:0] req_count;

    int checks = 0;
    int errors = 0;
    int deliveries = 0;
    int valid_cycles = 0;
    int timeouts = 0;

    bit         ack_q[$];
    logic [7:0] exp_q[$];

    post_host_input #(.POLL_MAX(8)) dut (
        .refclk        (refclk),
        .reset         (reset),
        .start         (start),
        .chain         (chain),
        .testreq       (testreq),
        .testack       (testack),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .busy          (busy),
        .timeout       (timeout),
        .pod_out_ready (pod_out_ready),
        .req_count     (req_count)
    );

    always #5 refclk = ~refclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pod model: each REQ rise presents the next scripted ACK bit.
    always @(posedge testreq) begin
        #1;
        testack = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
    end

    always @(negedge refclk) begin
        if (!reset) begin
            if (timeout) timeouts++;
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) begin
                deliveries++;
                if (exp_q.size() > 0) check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                else                  check_eq("rx_extra_byte", 32'(rx_data), 32'h100);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge refclk);
        #1 reset = 1'b0;
        ack_q.delete();
        exp_q.delete();
    endtask

    task automatic pod_cmd(input bit x, input bit y);
        ack_q.push_back(1'b0);
        ack_q.push_back(1'b0);
        ack_q.push_back(x);
        ack_q.push_back(y);
    endtask

    task automatic pod_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) ack_q.push_back(b[i]);
    endtask

    task automatic do_start(input string tag);
        int n;
        @(posedge refclk);
        #1 start = 1'b1;
        @(posedge refclk);
        #1 start = 1'b0;
        n = 1;
        while (!testreq && n < 200) begin
            @(posedge refclk);
            #1;
            n++;
        end
        check_eq(tag, n, 1 + BREAK_CYC);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge refclk);
            if (!busy) break;
        end
        check_eq("busy_clear", 32'(busy), 0);
    endtask

    initial begin
        int d0;
        int v0;
        int t0;
        int n;

        do_reset();
        @(negedge refclk);
        check_eq("rst_testreq", 32'(testreq), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_rx_valid", 32'(rx_valid), 0);
        check_eq("rst_rx_data", 32'(rx_data), 0);
        check_eq("rst_timeout", 32'(timeout), 0);
        check_eq("rst_pod_out_ready", 32'(pod_out_ready), 0);
        check_eq("rst_req_count", 32'(req_count), 0);

        // Poll timeout: pod never reports y=1
        do_reset();
        rx_ready = 1'b1;
        pod_cmd(1'b1, 1'b0);
        d0 = deliveries; t0 = timeouts;
        do_start("start_to_req_timeout");
        wait_idle();
        check_eq("timeout_req_count", 32'(req_count), 11);
        check_eq("timeout_pulses", timeouts - t0, 1);
        check_eq("timeout_no_byte", deliveries - d0, 0);
        check_eq("timeout_pod_out_ready", 32'(pod_out_ready), 1);

        // Single byte, no chaining
        do_reset();
        pod_cmd(1'b0, 1'b1);
        pod_byte(8'h5A);
        exp_q.push_back(8'h5A);
        d0 = deliveries; v0 = valid_cycles; t0 = timeouts;
        do_start("start_to_req_single");
        for (int i = 0; i < 2000; i++) begin
            @(negedge refclk);
            if (rx_valid) break;
        end
        n = 0;
        while (busy && n < 500) begin
            @(negedge refclk);
            n++;
        end
        check_eq("break_after_byte", n, 1 + BREAK_CYC);
        wait_idle();
        check_eq("single_req_count", 32'(req_count), 12);
        check_eq("single_deliveries", deliveries - d0, 1);
        check_eq("single_valid_cycles", valid_cycles - v0, 1);
        check_eq("single_no_timeout", timeouts - t0, 0);
        check_eq("single_pod_out_ready", 32'(pod_out_ready), 0);

        // Five bytes, chained when enabled
        do_reset();
        chain = 1'b1;
        d0 = deliveries;
`ifdef POST_HOST_CHAIN_EN
        pod_cmd(1'b0, 1'b1);
        pod_byte(8'h5A);
        for (int k = 0; k < 4; k++) begin
            ack_q.push_back(1'b1);
            pod_byte(8'h5A);
        end
        for (int k = 0; k < 5; k++) exp_q.push_back(8'h5A);
        do_start("start_to_req_chain");
        for (int i = 0; i < 5000; i++) begin
            @(negedge refclk);
            if (deliveries - d0 >= 4) break;
        end
        @(posedge refclk);
        #1 chain = 1'b0;
        wait_idle();
        check_eq("chain_req_count", 32'(req_count), 48);
`else
        for (int k = 0; k < 5; k++) begin
            pod_cmd(1'b0, 1'b1);
            pod_byte(8'h5A);
            exp_q.push_back(8'h5A);
            do_start("start_to_req_multi");
            wait_idle();
        end
        check_eq("multi_req_count", 32'(req_count), 60);
`endif
        check_eq("five_deliveries", deliveries - d0, 5);
        check_eq("five_sb_empty", exp_q.size(), 0);

        // Back-pressure: byte held, END taken, accepted once later
        do_reset();
        chain = 1'b1;
        rx_ready = 1'b0;
        pod_cmd(1'b0, 1'b1);
        pod_byte(8'h5A);
        ack_q.push_back(1'b1);
        pod_byte(8'h5A);
        exp_q.push_back(8'h5A);
        d0 = deliveries;
        do_start("start_to_req_hold");
        wait_idle();
        repeat (20) @(negedge refclk);
        check_eq("hold_req_count", 32'(req_count), 12);
        check_eq("hold_rx_valid", 32'(rx_valid), 1);
        check_eq("hold_rx_data", 32'(rx_data), 32'h5A);
        check_eq("hold_no_delivery", deliveries - d0, 0);
        @(posedge refclk);
        #1 rx_ready = 1'b1;
        repeat (5) @(negedge refclk);
        check_eq("hold_accept_once", deliveries - d0, 1);
        check_eq("hold_rx_valid_clear", 32'(rx_valid), 0);
        chain = 1'b0;

        // Three y=0 answers then a byte
        do_reset();
        pod_cmd(1'b0, 1'b0);
        ack_q.push_back(1'b0);
        ack_q.push_back(1'b0);
        ack_q.push_back(1'b1);
        pod_byte(8'hA5);
        exp_q.push_back(8'hA5);
        d0 = deliveries; t0 = timeouts;
        do_start("start_to_req_poll");
        wait_idle();
        check_eq("poll_req_count", 32'(req_count), 15);
        check_eq("poll_deliveries", deliveries - d0, 1);
        check_eq("poll_no_timeout", timeouts - t0, 0);

        // Reset during DATA bit 5, then a clean transaction
        do_reset();
        pod_cmd(1'b0, 1'b1);
        pod_byte(8'h5A);
        do_start("start_to_req_abort");
        for (int i = 0; i < 2000; i++) begin
            @(negedge refclk);
            if (req_count >= 16'd9) break;
        end
        check_eq("abort_at_bit5", 32'(req_count), 9);
        @(posedge refclk);
        #1 reset = 1'b1;
        @(posedge refclk);
        #1;
        check_eq("abort_testreq", 32'(testreq), 0);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_req_count", 32'(req_count), 0);
        check_eq("abort_rx_valid", 32'(rx_valid), 0);
        reset = 1'b0;
        ack_q.delete();
        exp_q.delete();
        pod_cmd(1'b0, 1'b1);
        pod_byte(8'h3C);
        exp_q.push_back(8'h3C);
        d0 = deliveries;
        do_start("start_to_req_after_abort");
        wait_idle();
        check_eq("after_abort_req_count", 32'(req_count), 12);
        check_eq("after_abort_deliveries", deliveries - d0, 1);
        check_eq("final_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
